alarm_ringer: RTL and testbench
===============================

Name: alarm_ringer

Overview:
- Downstream of the alarm FSM. Consumes its alarm_on match level and the current time, and drives the buzzer.
- Turns the level-type alarm match into a managed ringing session: beep pattern, snooze with re-arm time, stop, and auto-timeout.
- Single clock domain, the same clk as the time counter and the alarm FSM.

Parameters:
BEEP_HALF, 25_000_000, clk cycles per buzzer half-period (buzzer toggles at this interval)
SNOOZE_MIN, 5, minutes added to current time on snooze (1..59)
RING_TIMEOUT_MIN, 10, whole-minute rollovers of curr_min after which unattended ringing stops (1..59)
MAX_SNOOZE, 3, snooze presses honoured per session; further presses ignored

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
alarm_on  in  1  alarm match level from alarm FSM; high for the whole matching minute
btn_snooze  in  1  one-cycle pulse from debouncer
btn_stop  in  1  one-cycle pulse from debouncer
curr_hour  in  5  current hour 0..23
curr_min  in  6  current minute 0..59
buzzer  out  1  beep drive
ringing  out  1  high in RINGING
snoozed  out  1  high in SNOOZED
snooze_cnt  out  2  snoozes used this session
wake_hour  out  5  snooze re-ring hour
wake_min  out  6  snooze re-ring minute
missed  out  1  sticky; session ended by timeout

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; all outputs 0; beep counter, minute counter and alarm_on_d cleared.
  - Reset mid-ring stops the buzzer on the next edge.
- alarm_on_d registers alarm_on. Start condition: alarm_on & ~alarm_on_d (rising edge). A level held high never re-triggers.
- IDLE:
  - On start: go to RINGING next cycle; snooze_cnt=0; missed=0.
  - btn_snooze and btn_stop are ignored.
- RINGING:
  - ringing=1. Entry cycle: buzzer=1 and beep counter=0.
  - Buzzer toggles each time the counter reaches BEEP_HALF-1; the counter then wraps to 0.
  - Minute counter increments whenever curr_min differs from its value registered the previous cycle.
  - Priority, highest first: btn_stop > btn_snooze > timeout.
  - btn_stop: go to IDLE; buzzer=0.
  - btn_snooze with snooze_cnt<MAX_SNOOZE: go to SNOOZED; snooze_cnt+1.
    - wake_min=(curr_min+SNOOZE_MIN) mod 60.
    - If that wrapped, wake_hour=(curr_hour+1) mod 24; else wake_hour=curr_hour.
    - Example: 23:58 + 5 gives 00:03.
  - btn_snooze with snooze_cnt==MAX_SNOOZE: ignored; keep ringing.
  - Minute counter reaching RING_TIMEOUT_MIN: go to IDLE; missed=1; buzzer=0.
- SNOOZED:
  - snoozed=1; buzzer=0.
  - When curr_hour==wake_hour and curr_min==wake_min: go to RINGING with counters reset as on entry.
  - btn_stop: go to IDLE.
  - btn_snooze: ignored.
  - A start edge while snoozed is ignored; the session continues.
- ringing, snoozed and buzzer are registered outputs with one cycle latency from the causing input.
- missed clears only on a new start or on reset.
- Arithmetic: wake_min computed in 7 bits before the mod. All time comparisons are unsigned.

Optional Feature:
- Macro: ALARM_ESCALATE_EN.
- Defined: once the RINGING minute counter is ≥1, the buzzer toggle interval becomes BEEP_HALF/2 (integer, minimum 1). It reverts to BEEP_HALF on each RINGING entry.
- Undefined: fixed BEEP_HALF interval throughout.

Decomposition:
- Shared package (alarm_pkg): state encoding constants (IDLE, RINGING, SNOOZED), HOUR_MAX=23, MIN_MAX=59, and the hour/min widths (5/6) used by the time counter, alarm FSM and this block.
- One natural sub-module: beep_gen. It holds the beep counter and toggle, with inputs enable, restart and half-period select, and output buzzer.

Test Plan:
(BEEP_HALF=4, SNOOZE_MIN=5, RING_TIMEOUT_MIN=2, MAX_SNOOZE=3)
- Ring and stop:
  - alarm_on 0→1 at 07:30 → ringing=1 next cycle; buzzer 1,1,1,1,0,0,0,0,1…
  - btn_stop → ringing=0, buzzer=0 next cycle.
  - alarm_on kept high afterwards → no re-ring.
- Snooze across midnight:
  - Ringing at 23:58, btn_snooze → snoozed=1, wake=00:03, snooze_cnt=1.
  - Drive time to 00:03 → ringing=1.
- Snooze limit:
  - Three snooze/re-ring cycles → snooze_cnt=3.
  - Fourth btn_snooze → ringing remains 1, state unchanged.
- Timeout:
  - Ringing, no buttons, curr_min steps 30→31→32 → ringing=0, missed=1.
  - Next alarm_on rising edge → missed=0.
- Simultaneous press:
  - btn_stop and btn_snooze in the same cycle while ringing → IDLE; snooze_cnt unchanged; snoozed=0.
- Reset mid-operation:
  - reset=0 for one cycle while ringing with buzzer=1 → all outputs 0 on that edge.
  - alarm_on still high after release → no ring.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock datapath: time field widths,
// time limits and the ringer state encoding used by the time counter,
// the alarm FSM and the alarm ringer.
package alarm_pkg;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ringState_t;

    // Next hour with midnight wrap, used when a snooze crosses an hour boundary
    function automatic logic [HOUR_W-1:0] nextHour(input logic [HOUR_W-1:0] hour);
        logic [HOUR_W-1:0] result;
        if (hour == HOUR_W'(HOUR_MAX)) begin
            result = '0;
        end else begin
            result = hour + HOUR_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/alarm_ringer_beep_gen.sv
// Buzzer pattern generator for the alarm ringer. A restart forces the
// buzzer high with a fresh count; while enabled the buzzer toggles every
// half-period; when disabled the buzzer is held low.
module beep_gen #(
    parameter int HALF_SLOW = 25_000_000,
    parameter int HALF_FAST = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_restart,
    input  logic i_fastSel,
    output logic o_buzzer
);

    localparam int CW = (HALF_SLOW > 1) ? $clog2(HALF_SLOW) : 1;

    logic [CW-1:0] r_count;
    logic          r_buzzer;
    logic [CW-1:0] w_limit;

    // Terminal count for the active half-period; >= is used below so a
    // switch to the shorter period mid-count still wraps cleanly
    assign w_limit = i_fastSel ? CW'(HALF_FAST - 1) : CW'(HALF_SLOW - 1);

    // Half-period counter and buzzer toggle flop
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count  <= '0;
            r_buzzer <= 1'b0;
        end else if (i_restart) begin
            r_count  <= '0;
            r_buzzer <= 1'b1;
        end else if (i_enable) begin
            if (r_count >= w_limit) begin
                r_count  <= '0;
                r_buzzer <= ~r_buzzer;
            end else begin
                r_count  <= r_count + CW'(1);
            end
        end else begin
            r_count  <= '0;
            r_buzzer <= 1'b0;
        end
    end

    assign o_buzzer = r_buzzer;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns the alarm FSM's match level into a ringing session
// with beep pattern, snooze (with re-arm time), stop and unattended timeout.
// Optional macro ALARM_ESCALATE_EN halves the beep half-period once the
// session has rung through at least one minute rollover.
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int BEEP_HALF        = 25_000_000,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alarm_on,
    input  logic              btn_snooze,
    input  logic              btn_stop,
    input  logic [HOUR_W-1:0] curr_hour,
    input  logic [MIN_W-1:0]  curr_min,
    output logic              buzzer,
    output logic              ringing,
    output logic              snoozed,
    output logic [1:0]        snooze_cnt,
    output logic [HOUR_W-1:0] wake_hour,
    output logic [MIN_W-1:0]  wake_min,
    output logic              missed
);

    localparam int BEEP_FAST = (BEEP_HALF / 2 < 1) ? 1 : BEEP_HALF / 2;

    ringState_t        r_state;
    ringState_t        w_nextState;
    logic              r_alarmOnD;
    logic              r_needLow;
    logic [MIN_W-1:0]  r_prevMin;
    logic [MIN_W-1:0]  r_minCnt;
    logic [1:0]        r_snoozeCnt;
    logic [HOUR_W-1:0] r_wakeHour;
    logic [MIN_W-1:0]  r_wakeMin;
    logic              r_missed;
    logic              r_ringing;
    logic              r_snoozed;

    logic              w_start;
    logic              w_minStep;
    logic              w_timeout;
    logic              w_wakeMatch;
    logic              w_snoozeOk;
    logic              w_doSnooze;
    logic              w_doTimeout;
    logic              w_enterRing;
    logic              w_beepEnable;
    logic              w_fastSel;
    logic [6:0]        w_wakeSum;
    logic              w_wakeWrap;
    logic [MIN_W-1:0]  w_wakeMinCalc;
    logic [HOUR_W-1:0] w_wakeHourCalc;

    // A level already high when reset is released must not look like a new
    // match, so after reset alarm_on has to be seen low before edges count
    assign w_start     = alarm_on & ~r_alarmOnD & ~r_needLow;
    assign w_minStep   = (curr_min != r_prevMin);
    assign w_timeout   = (r_minCnt >= MIN_W'(RING_TIMEOUT_MIN));
    assign w_wakeMatch = (curr_hour == r_wakeHour) && (curr_min == r_wakeMin);
    assign w_snoozeOk  = (r_snoozeCnt < 2'(MAX_SNOOZE));

    assign w_wakeSum      = {1'b0, curr_min} + 7'(SNOOZE_MIN);
    assign w_wakeWrap     = (w_wakeSum > 7'(MIN_MAX));
    assign w_wakeMinCalc  = w_wakeWrap ? (w_wakeSum[MIN_W-1:0] - MIN_W'(MIN_MAX + 1))
                                       : w_wakeSum[MIN_W-1:0];
    assign w_wakeHourCalc = w_wakeWrap ? nextHour(curr_hour) : curr_hour;

    // Next-state decode; stop beats snooze, snooze beats timeout
    always_comb begin
        w_nextState = r_state;
        w_doSnooze  = 1'b0;
        w_doTimeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = RINGING;
                end
            end
            RINGING: begin
                if (btn_stop) begin
                    w_nextState = IDLE;
                end else if (btn_snooze && w_snoozeOk) begin
                    w_nextState = SNOOZED;
                    w_doSnooze  = 1'b1;
                end else if (w_timeout) begin
                    w_nextState = IDLE;
                    w_doTimeout = 1'b1;
                end
            end
            SNOOZED: begin
                if (btn_stop) begin
                    w_nextState = IDLE;
                end else if (w_wakeMatch) begin
                    w_nextState = RINGING;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_enterRing  = (w_nextState == RINGING) && (r_state != RINGING);
    assign w_beepEnable = (w_nextState == RINGING);

`ifdef ALARM_ESCALATE_EN
    assign w_fastSel = (r_minCnt != '0);
`else
    assign w_fastSel = 1'b0;
`endif

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ringing <= 1'b0;
            r_snoozed <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ringing <= (w_nextState == RINGING);
            r_snoozed <= (w_nextState == SNOOZED);
        end
    end

    // Input history: alarm edge detect, post-reset arming and minute change
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_alarmOnD <= 1'b0;
            r_needLow  <= 1'b1;
            r_prevMin  <= '0;
        end else begin
            r_alarmOnD <= alarm_on;
            r_prevMin  <= curr_min;
            if (!alarm_on) begin
                r_needLow <= 1'b0;
            end
        end
    end

    // Minute rollovers seen while ringing; cleared on every ringing entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_minCnt <= '0;
        end else if (w_enterRing) begin
            r_minCnt <= '0;
        end else if ((r_state == RINGING) && w_minStep) begin
            r_minCnt <= r_minCnt + MIN_W'(1);
        end
    end

    // Session bookkeeping: snooze count, wake time and sticky missed flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snoozeCnt <= '0;
            r_wakeHour  <= '0;
            r_wakeMin   <= '0;
            r_missed    <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_start) begin
                r_snoozeCnt <= '0;
                r_missed    <= 1'b0;
            end
            if (w_doSnooze) begin
                r_snoozeCnt <= r_snoozeCnt + 2'd1;
                r_wakeHour  <= w_wakeHourCalc;
                r_wakeMin   <= w_wakeMinCalc;
            end
            if (w_doTimeout) begin
                r_missed <= 1'b1;
            end
        end
    end

    beep_gen #(
        .HALF_SLOW (BEEP_HALF),
        .HALF_FAST (BEEP_FAST)
    ) uBeepGen (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (w_beepEnable),
        .i_restart (w_enterRing),
        .i_fastSel (w_fastSel),
        .o_buzzer  (buzzer)
    );

    assign ringing    = r_ringing;
    assign snoozed    = r_snoozed;
    assign snooze_cnt = r_snoozeCnt;
    assign wake_hour  = r_wakeHour;
    assign wake_min   = r_wakeMin;
    assign missed     = r_missed;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with BEEP_HALF=4, SNOOZE_MIN=5,
// RING_TIMEOUT_MIN=2, MAX_SNOOZE=3.
module tb_alarm_ringer;

    logic       clk = 1'b0;
    logic       reset;
    logic       alarm_on;
    logic       btn_snooze;
    logic       btn_stop;
    logic [4:0] curr_hour;
    logic [5:0] curr_min;
    logic       buzzer;
    logic       ringing;
    logic       snoozed;
    logic [1:0] snooze_cnt;
    logic [4:0] wake_hour;
    logic [5:0] wake_min;
    logic       missed;

    int testsRun    = 0;
    int testsFailed = 0;

    alarm_ringer #(
        .BEEP_HALF        (4),
        .SNOOZE_MIN       (5),
        .RING_TIMEOUT_MIN (2),
        .MAX_SNOOZE       (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alarm_on   (alarm_on),
        .btn_snooze (btn_snooze),
        .btn_stop   (btn_stop),
        .curr_hour  (curr_hour),
        .curr_min   (curr_min),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .snooze_cnt (snooze_cnt),
        .wake_hour  (wake_hour),
        .wake_min   (wake_min),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a session at hh:mm by producing a clean alarm_on rising edge
    task automatic startRing(input logic [4:0] hh, input logic [5:0] mm);
        alarm_on  = 1'b0;
        curr_hour = hh;
        curr_min  = mm;
        tick(1);
        alarm_on = 1'b1;
        tick(1);
    endtask

    task automatic pressStop();
        btn_stop = 1'b1;
        tick(1);
        btn_stop = 1'b0;
    endtask

    task automatic pressSnooze();
        btn_snooze = 1'b1;
        tick(1);
        btn_snooze = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(2);
        testsRun++; if (ringing !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ringing: got %b expected 0", ringing); end
        testsRun++; if (snoozed !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_snoozed: got %b expected 0", snoozed); end
        testsRun++; if (buzzer !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_buzzer: got %b expected 0", buzzer); end
        testsRun++; if (snooze_cnt !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_snooze_cnt: got %0d expected 0", snooze_cnt); end
        testsRun++; if (wake_hour !== 5'd0 || wake_min !== 6'd0) begin testsFailed++; $display("[TB] FAIL reset_wake: got %0d:%0d expected 0:0", wake_hour, wake_min); end
        testsRun++; if (missed !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_missed: got %b expected 0", missed); end
        reset = 1'b1;
        tick(1);
        pressSnooze();
        pressStop();
        tick(1);
        testsRun++; if (ringing !== 1'b0 || snoozed !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_buttons_ignored: got ringing=%b snoozed=%b expected 0/0", ringing, snoozed); end
    endtask

    task automatic test_ring_and_stop();
        int expBuzz[8] = '{1, 1, 1, 0, 0, 0, 0, 1};
        startRing(5'd7, 6'd30);
        testsRun++; if (ringing !== 1'b1) begin testsFailed++; $display("[TB] FAIL ring_start: got ringing=%b expected 1", ringing); end
        testsRun++; if (buzzer !== 1'b1) begin testsFailed++; $display("[TB] FAIL ring_entry_buzzer: got %b expected 1", buzzer); end
        for (int i = 0; i < 8; i++) begin
            tick(1);
            testsRun++; if (buzzer !== expBuzz[i][0]) begin testsFailed++; $display("[TB] FAIL beep_pattern[%0d]: got %b expected %0d", i, buzzer, expBuzz[i]); end
        end
        pressStop();
        testsRun++; if (ringing !== 1'b0 || buzzer !== 1'b0) begin testsFailed++; $display("[TB] FAIL stop: got ringing=%b buzzer=%b expected 0/0", ringing, buzzer); end
        tick(5);
        testsRun++; if (ringing !== 1'b0) begin testsFailed++; $display("[TB] FAIL held_level_no_rering: got ringing=%b expected 0", ringing); end
        alarm_on = 1'b0;
        tick(1);
    endtask

    task automatic test_snooze_midnight();
        startRing(5'd23, 6'd58);
        testsRun++; if (ringing !== 1'b1) begin testsFailed++; $display("[TB] FAIL midnight_ring: got ringing=%b expected 1", ringing); end
        pressSnooze();
        testsRun++; if (snoozed !== 1'b1 || ringing !== 1'b0 || buzzer !== 1'b0) begin testsFailed++; $display("[TB] FAIL midnight_snoozed: got snoozed=%b ringing=%b buzzer=%b expected 1/0/0", snoozed, ringing, buzzer); end
        testsRun++; if (wake_hour !== 5'd0 || wake_min !== 6'd3) begin testsFailed++; $display("[TB] FAIL midnight_wake: got %0d:%0d expected 0:3", wake_hour, wake_min); end
        testsRun++; if (snooze_cnt !== 2'd1) begin testsFailed++; $display("[TB] FAIL midnight_snooze_cnt: got %0d expected 1", snooze_cnt); end
        alarm_on  = 1'b0;
        curr_hour = 5'd0;
        curr_min  = 6'd2;
        tick(2);
        testsRun++; if (snoozed !== 1'b1) begin testsFailed++; $display("[TB] FAIL midnight_early: got snoozed=%b expected 1", snoozed); end
        curr_min = 6'd3;
        tick(1);
        testsRun++; if (ringing !== 1'b1 || snoozed !== 1'b0 || buzzer !== 1'b1) begin testsFailed++; $display("[TB] FAIL midnight_rering: got ringing=%b snoozed=%b buzzer=%b expected 1/0/1", ringing, snoozed, buzzer); end
        pressStop();
    endtask

    task automatic test_snooze_limit();
        int m = 0;
        startRing(5'd6, 6'd0);
        alarm_on = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            pressSnooze();
            testsRun++; if (snoozed !== 1'b1 || snooze_cnt !== 2'(k)) begin testsFailed++; $display("[TB] FAIL limit_snooze%0d: got snoozed=%b cnt=%0d expected 1/%0d", k, snoozed, snooze_cnt, k); end
            testsRun++; if (wake_hour !== 5'd6 || wake_min !== 6'(m + 5)) begin testsFailed++; $display("[TB] FAIL limit_wake%0d: got %0d:%0d expected 6:%0d", k, wake_hour, wake_min, m + 5); end
            if (k == 1) begin
                alarm_on = 1'b1;
                tick(2);
                testsRun++; if (snoozed !== 1'b1 || ringing !== 1'b0) begin testsFailed++; $display("[TB] FAIL start_while_snoozed: got snoozed=%b ringing=%b expected 1/0", snoozed, ringing); end
                alarm_on = 1'b0;
            end
            m = m + 5;
            curr_min = 6'(m);
            tick(1);
            testsRun++; if (ringing !== 1'b1) begin testsFailed++; $display("[TB] FAIL limit_rering%0d: got ringing=%b expected 1", k, ringing); end
        end
        pressSnooze();
        tick(1);
        testsRun++; if (ringing !== 1'b1 || snoozed !== 1'b0 || snooze_cnt !== 2'd3) begin testsFailed++; $display("[TB] FAIL limit_fourth_ignored: got ringing=%b snoozed=%b cnt=%0d expected 1/0/3", ringing, snoozed, snooze_cnt); end
        pressStop();
    endtask

    task automatic test_timeout();
        bit done = 0;
        startRing(5'd8, 6'd30);
        alarm_on = 1'b0;
        curr_min = 6'd31;
        tick(2);
        testsRun++; if (ringing !== 1'b1 || missed !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_one_minute: got ringing=%b missed=%b expected 1/0", ringing, missed); end
        curr_min = 6'd32;
        for (int i = 0; i < 4 && !done; i++) begin
            tick(1);
            if (ringing === 1'b0) done = 1;
        end
        testsRun++; if (!done) begin testsFailed++; $display("[TB] FAIL timeout_stop: got ringing=%b expected 0 within 4 cycles", ringing); end
        testsRun++; if (missed !== 1'b1 || buzzer !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_missed: got missed=%b buzzer=%b expected 1/0", missed, buzzer); end
        tick(3);
        testsRun++; if (missed !== 1'b1) begin testsFailed++; $display("[TB] FAIL missed_sticky: got %b expected 1", missed); end
        startRing(5'd8, 6'd45);
        testsRun++; if (ringing !== 1'b1 || missed !== 1'b0) begin testsFailed++; $display("[TB] FAIL missed_clear: got ringing=%b missed=%b expected 1/0", ringing, missed); end
        alarm_on = 1'b0;
        pressStop();
    endtask

    task automatic test_simultaneous();
        startRing(5'd9, 6'd0);
        alarm_on = 1'b0;
        pressSnooze();
        curr_min = 6'd5;
        tick(1);
        testsRun++; if (ringing !== 1'b1 || snooze_cnt !== 2'd1) begin testsFailed++; $display("[TB] FAIL simul_setup: got ringing=%b cnt=%0d expected 1/1", ringing, snooze_cnt); end
        btn_stop   = 1'b1;
        btn_snooze = 1'b1;
        tick(1);
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
        testsRun++; if (ringing !== 1'b0 || snoozed !== 1'b0 || buzzer !== 1'b0) begin testsFailed++; $display("[TB] FAIL simul_idle: got ringing=%b snoozed=%b buzzer=%b expected 0/0/0", ringing, snoozed, buzzer); end
        testsRun++; if (snooze_cnt !== 2'd1) begin testsFailed++; $display("[TB] FAIL simul_cnt: got %0d expected 1", snooze_cnt); end
    endtask

    task automatic test_reset_mid_ring();
        startRing(5'd10, 6'd0);
        testsRun++; if (ringing !== 1'b1 || buzzer !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_reset_setup: got ringing=%b buzzer=%b expected 1/1", ringing, buzzer); end
        reset = 1'b0;
        tick(1);
        testsRun++; if (ringing !== 1'b0 || buzzer !== 1'b0 || snoozed !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_outputs: got ringing=%b buzzer=%b snoozed=%b expected 0/0/0", ringing, buzzer, snoozed); end
        testsRun++; if (wake_hour !== 5'd0 || wake_min !== 6'd0 || snooze_cnt !== 2'd0 || missed !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_session: got wake=%0d:%0d cnt=%0d missed=%b expected 0:0/0/0", wake_hour, wake_min, snooze_cnt, missed); end
        reset = 1'b1;
        tick(4);
        testsRun++; if (ringing !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset_no_ring: got ringing=%b expected 0", ringing); end
        startRing(5'd10, 6'd1);
        testsRun++; if (ringing !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_ring: got ringing=%b expected 1", ringing); end
        alarm_on = 1'b0;
        pressStop();
    endtask

    initial begin
        reset      = 1'b0;
        alarm_on   = 1'b0;
        btn_snooze = 1'b0;
        btn_stop   = 1'b0;
        curr_hour  = 5'd0;
        curr_min   = 6'd0;
        test_reset();
        test_ring_and_stop();
        test_snooze_midnight();
        test_snooze_limit();
        test_timeout();
        test_simultaneous();
        test_reset_mid_ring();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
